fp32_square_iter: RTL
=====================

# fp32_square_iter

Iterative IEEE-754 binary32 squaring unit, the inverse of the Newton-Raphson square-root core in the floating-point sqrt datapath. It takes a single-precision operand on a one-cycle start strobe, forms the 24x24 significand product with a radix-4 shift-add loop, then normalises, rounds to nearest-even and packs the result. It shares the start/busy/ready/count handshake of the sqrt core, so the same sequencer drives both, and it is used for sqrt self-checking (q*q ≈ d).

## Interface
- No parameters. Format is fixed at IEEE-754 binary32 and rounding at round-to-nearest-even.
- Clock and reset (already decided): reset reset, asynchronous, active-low; clock clk.
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; a is sampled on the same edge.
- a  in  32  binary32 operand.
- q  out  32  binary32 result a*a; registered.
- busy  out  1  iteration in progress.
- ready  out  1  q valid; held until the next start.
- count  out  4  iteration index, 0..11.

## Operation
- States: IDLE, ITER, ROUND. After reset the block is in IDLE.
- start may be asserted in any state. It aborts any work in progress and restarts.
- On start:
  - Latch a.
  - Classify the operand as ZERO, SUBNORMAL, NORMAL, INF or NAN.
  - Clear the accumulator, set count=0, set busy=1 and ready=0, enter ITER.
  - q keeps its previous value until the new result completes.
- Sign: always 0 in the result, since a square is non-negative.
- Significand m = {1, a[22:0]}, 24 bits. Product P = m*m, 48 bits, lies in [2^46, 2^48).
- ITER, one cycle per count value 0..11:
  - Take the multiplier digit m[2c+1:2c], where c = count.
  - Add digit*m (one of 0, m, 2m, 3m) shifted left by 2c into the 48-bit accumulator.
  - Increment count. After count 11, enter ROUND and hold count at 11.
- ROUND, one cycle. The sub-steps below describe combinational logic feeding q:
  - Normalise: n = P[47].
    - If n=1: frac = P[46:24], guard = P[23], sticky = |P[22:0].
    - If n=0: frac = P[45:23], guard = P[22], sticky = |P[21:0].
  - Exponent: a signed 10-bit value, E = 2*a[30:23] − 127 + n.
  - Rounding: round up when guard & (sticky | frac[0]). A carry out of frac zeroes frac and adds 1 to E.
  - Overflow: if E ≥ 255, q = 0x7F800000.
  - Underflow: if E ≤ 0, q = 0x00000000. Subnormal results are flushed; no subnormals are produced.
  - Otherwise q = {0, E[7:0], frac}.
  - Then busy=0, ready=1, return to IDLE.
- Special operands run the full 13-cycle sequence, so latency is constant. At ROUND they override the datapath result:
  - ZERO or SUBNORMAL input (inputs are flushed to zero): q = 0x00000000.
  - INF of either sign: q = 0x7F800000.
  - NAN: q = 0x7FC00000, the canonical quiet NaN.
- Reset while active (mid-operation) returns to IDLE with all outputs at their reset values. The partial result is discarded.

## Timing
- Reset values: q=0, busy=0, ready=0, count=0, state IDLE.
- The edge that samples start is edge 0.
  - busy is high after edge 0.
  - The iterations occur at edges 1..12.
  - ROUND is performed at edge 13; q is updated there, with busy=0 and ready=1.
- Start-to-ready latency is 13 cycles. Throughput is one operation per 13 cycles.
- start asserted on the same edge as ROUND: start wins. The result is not written, ready stays 0, and the new operation begins.
- ready stays 1 and q stays stable in IDLE until the edge after the next start. That edge clears ready.
- count is visible to the sequencer. It reads 0..11 during ITER and holds 11 in ROUND and IDLE until the next start.

## Structure
- Package fp32_pkg holds:
  - BIAS=127, EXP_W=8, FRAC_W=23;
  - the constants QNAN=0x7FC00000, PINF=0x7F800000, PZERO=0x00000000;
  - a class enum {ZERO, SUBNORMAL, NORMAL, INF, NAN};
  - a classify function shared with the sqrt datapath.
- Sub-module fp32_round_rne: a combinational normalise/round/pack stage with inputs P[47:0] and signed E; outputs q, ovf and unf. It is reused by later binary32 units.
- The top level holds the state machine, the accumulator, count, the operand registers and the special-case override.

## Test plan
- a=0x3F800000 (1.0) → after exactly 13 cycles, ready=1, busy=0, q=0x3F800000. busy is high on cycles 1..12 and count steps 0..11.
- a=0x3FC00000 (1.5) → q=0x40100000 (2.25). a=0xC0400000 (−3.0) → q=0x41100000 (9.0), sign cleared.
- a=0x3F800001 → q=0x3F800002; the rounding discards the 2^-46 term. a=0x3FB504F3 → q=0x3FFFFFFF, exercising the guard/sticky path.
- Range limits:
  - a=0x5F800000 (2^64) → q=0x7F800000.
  - a=0x1F800000 (2^-64) → q=0x00000000.
  - a=0x00000001 (subnormal) → q=0x00000000.
- Special operands:
  - a=0x7FC00001 → q=0x7FC00000.
  - a=0xFF800000 → q=0x7F800000.
  - Each takes the same 13-cycle latency.
- Control boundaries:
  - Reset asserted at cycle 5 → busy=0, ready=0, q=0, count=0.
  - Re-start at cycle 6 of a busy operation with a=0x40000000 → q=0x40800000, exactly 13 cycles after the second start, with no ready pulse from the aborted operation.

Source files
------------

// File: rtl/fp32_pkg.sv
// Shared binary32 constants, operand classes and the classifier used by
// the square and sqrt datapaths.
package fp32_pkg;

    localparam int unsigned BIAS   = 127;
    localparam int unsigned EXP_W  = 8;
    localparam int unsigned FRAC_W = 23;

    localparam logic [31:0] QNAN  = 32'h7FC0_0000;
    localparam logic [31:0] PINF  = 32'h7F80_0000;
    localparam logic [31:0] PZERO = 32'h0000_0000;

    typedef enum logic [2:0] {
        ZERO,
        SUBNORMAL,
        NORMAL,
        INF,
        NAN
    } fp_class_e;

    function automatic fp_class_e classify(input logic [31:0] x);
        logic [EXP_W-1:0]  exp_f;
        logic [FRAC_W-1:0] frac_f;
        exp_f  = x[30:23];
        frac_f = x[22:0];
        if (exp_f == '0) begin
            classify = (frac_f == '0) ? ZERO : SUBNORMAL;
        end else if (exp_f == '1) begin
            classify = (frac_f == '0) ? INF : NAN;
        end else begin
            classify = NORMAL;
        end
    endfunction

endpackage

// File: rtl/fp32_square_iter_if.sv
// Start/busy/ready/count handshake shared by the iterative binary32 units.
interface fp32_square_iter_if;

    logic        start;
    logic [31:0] a;
    logic [31:0] q;
    logic        busy;
    logic        ready;
    logic [3:0]  count;

    modport master (
        output start, a,
        input  q, busy, ready, count
    );

    modport slave (
        input  start, a,
        output q, busy, ready, count
    );

endinterface

// File: rtl/fp32_round_rne.sv
// Combinational normalise / round-to-nearest-even / pack of a 48-bit
// significand product. i_e is the exponent before the normalisation shift.
module fp32_round_rne
    import fp32_pkg::*;
(
    input  logic [47:0]       i_p,
    input  logic signed [9:0] i_e,
    output logic [31:0]       o_q,
    output logic              o_ovf,
    output logic              o_unf
);

    logic              w_n;
    logic [22:0]       w_frac;
    logic              w_guard;
    logic              w_sticky;
    logic              w_up;
    logic [23:0]       w_sum;
    logic signed [9:0] w_e;

    always_comb begin
        w_n = i_p[47];
        if (w_n) begin
            w_frac   = i_p[46:24];
            w_guard  = i_p[23];
            w_sticky = |i_p[22:0];
        end else begin
            w_frac   = i_p[45:23];
            w_guard  = i_p[22];
            w_sticky = |i_p[21:0];
        end
        w_up  = w_guard & (w_sticky | w_frac[0]);
        // A carry out leaves w_sum[22:0] all zero, so only the exponent moves.
        w_sum = {1'b0, w_frac} + {23'b0, w_up};
        w_e   = i_e + $signed({9'b0, w_n}) + $signed({9'b0, w_sum[23]});

        o_ovf = (w_e >= 10'sd255);
        o_unf = (w_e <= 10'sd0);
        if (o_ovf) begin
            o_q = PINF;
        end else if (o_unf) begin
            o_q = PZERO;
        end else begin
            o_q = {1'b0, w_e[7:0], w_sum[22:0]};
        end
    end

endmodule

// File: rtl/fp32_square_iter.sv
// Iterative binary32 squarer: radix-4 shift-add significand product over
// 12 cycles, then one round/pack cycle. Constant 13-cycle latency.
module fp32_square_iter
    import fp32_pkg::*;
(
    input logic               clk,
    input logic               reset,
    fp32_square_iter_if.slave bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ITER  = 2'd1;
    localparam logic [1:0] ST_ROUND = 2'd2;

    logic [1:0]      r_state;
    logic [3:0]      r_count;
    logic [47:0]     r_acc;
    logic [23:0]     r_m;
    logic [7:0]      r_exp;
    fp_class_e       r_class;
    logic [31:0]     r_q;
    logic            r_busy;
    logic            r_ready;

    logic [1:0]        w_digit;
    logic [47:0]       w_mcand;
    logic [47:0]       w_pp;
    logic [47:0]       w_addend;
    logic signed [9:0] w_e;
    logic [31:0]       w_q_rnd;
    logic              w_ovf;
    logic              w_unf;
    logic [31:0]       w_q_final;

    always_comb begin
        w_digit  = r_m[{r_count, 1'b0} +: 2];
        w_mcand  = {24'b0, r_m};
        case (w_digit)
            2'd0:    w_pp = '0;
            2'd1:    w_pp = w_mcand;
            2'd2:    w_pp = w_mcand << 1;
            default: w_pp = w_mcand + (w_mcand << 1);
        endcase
        w_addend = w_pp << {r_count, 1'b0};
        // 2*exp - BIAS; the {0,exp,0} form stays positive in 10 signed bits.
        w_e      = 10'({1'b0, r_exp, 1'b0}) - 10'(BIAS);
    end

    fp32_round_rne u_round (
        .i_p   (r_acc),
        .i_e   (w_e),
        .o_q   (w_q_rnd),
        .o_ovf (w_ovf),
        .o_unf (w_unf)
    );

    always_comb begin
        case (r_class)
            ZERO, SUBNORMAL: w_q_final = PZERO;
            INF:             w_q_final = PINF;
            NAN:             w_q_final = QNAN;
            default:         w_q_final = w_q_rnd;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_acc   <= '0;
            r_m     <= '0;
            r_exp   <= '0;
            r_class <= ZERO;
            r_q     <= '0;
            r_busy  <= 1'b0;
            r_ready <= 1'b0;
        end else if (bus.start) begin
            r_m     <= {1'b1, bus.a[22:0]};
            r_exp   <= bus.a[30:23];
            r_class <= classify(bus.a);
            r_acc   <= '0;
            r_count <= '0;
            r_busy  <= 1'b1;
            r_ready <= 1'b0;
            r_state <= ST_ITER;
        end else begin
            case (r_state)
                ST_ITER: begin
                    r_acc <= r_acc + w_addend;
                    if (r_count == 4'd11) begin
                        r_state <= ST_ROUND;
                    end else begin
                        r_count <= r_count + 4'd1;
                    end
                end
                ST_ROUND: begin
                    r_q     <= w_q_final;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: ;
            endcase
        end
    end

    assign bus.q     = r_q;
    assign bus.busy  = r_busy;
    assign bus.ready = r_ready;
    assign bus.count = r_count;

    logic w_unused;
    assign w_unused = w_ovf ^ w_unf;

endmodule
